// File: rtl/two_channel_square_wave_decoder.sv
// Two independent square-wave divisor decoders.
// A channel locks once two consecutive half periods agree.
module sqw_chan_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sq,
  output logic [7:0] div,
  output logic       valid,
  output logic       upd
);
  typedef enum logic [1:0] {IDLE, FIRST, MEAS, LOCK} state_t;

  state_t     state, state_n;
  logic       s1, s2, prev, tog;
  logic [8:0] cnt;
  logic [7:0] cand, cand_n, div_n, hm1;
  logic       valid_n, in_rng;

  assign tog    = s2 != prev;
  assign hm1    = 8'(cnt - 9'd1);
  assign in_rng = (cnt >= 9'd2) && (cnt <= 9'd256);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      prev  <= 1'b0;
      cnt   <= 9'd0;
      state <= IDLE;
      cand  <= 8'd0;
      div   <= 8'd0;
      valid <= 1'b0;
      upd   <= 1'b0;
    end else begin
      s1    <= sq;
      s2    <= s1;
      prev  <= s2;
      if (tog)
        cnt <= 9'd1;
      else if (cnt != 9'd511)
        cnt <= cnt + 9'd1;
      state <= state_n;
      cand  <= cand_n;
      div   <= div_n;
      valid <= valid_n;
      upd   <= (div_n != div) || (valid_n != valid);
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    div_n   = div;
    valid_n = valid;
    if (tog) begin
      if (state == IDLE) begin
        state_n = FIRST;
      end else if (cnt == 9'd1) begin
        // one-cycle pulse: restart measurement, keep last divisor
        state_n = FIRST;
        valid_n = 1'b0;
      end else if (in_rng) begin
        unique case (state)
          FIRST: begin
            cand_n  = hm1;
            state_n = MEAS;
          end
          MEAS: begin
            if (hm1 == cand) begin
              state_n = LOCK;
              div_n   = cand;
              valid_n = 1'b1;
            end else begin
              cand_n = hm1;
            end
          end
          LOCK: begin
            if (hm1 != cand) begin
              cand_n  = hm1;
              state_n = MEAS;
              valid_n = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end else if (state != IDLE && cnt == 9'd257) begin
      state_n = IDLE;
      div_n   = 8'd0;
      valid_n = 1'b0;
    end
  end
endmodule

module two_channel_square_wave_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sq_a,
  input  logic       sq_b,
  output logic [7:0] div_a,
  output logic       valid_a,
  output logic       upd_a,
  output logic [7:0] div_b,
  output logic       valid_b,
  output logic       upd_b
);
  sqw_chan_stage u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .sq    (sq_a),
    .div   (div_a),
    .valid (valid_a),
    .upd   (upd_a)
  );

  sqw_chan_stage u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .sq    (sq_b),
    .div   (div_b),
    .valid (valid_b),
    .upd   (upd_b)
  );
endmodule

// File: tb/tb_two_channel_square_wave_decoder.sv
// Bench for two_channel_square_wave_decoder.
// Vector table, directed corner cases and random traffic vs a timestamp model.
module tb_two_channel_square_wave_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sq_a = 1'b0;
  logic       sq_b = 1'b0;
  logic [7:0] div_a, div_b;
  logic       valid_a, upd_a, valid_b, upd_b;

  always #5 clk = ~clk;

  two_channel_square_wave_decoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sq_a    (sq_a),
    .sq_b    (sq_b),
    .div_a   (div_a),
    .valid_a (valid_a),
    .upd_a   (upd_a),
    .div_b   (div_b),
    .valid_b (valid_b),
    .upd_b   (upd_b)
  );

  int tests = 0;
  int fails = 0;

  // reference model: index 0 = A, 1 = B
  logic [2:0] mh [2];
  bit         mrun [2];
  int         mlast [2];
  int         miv [2][2];
  int         mniv [2];
  logic [7:0] mdiv [2];
  logic       mval [2];
  logic       mupd [2];
  int         mt = 0;

  task automatic mdl(input int c, input logic s);
    logic       ev;
    logic [7:0] od;
    logic       ov;
    int         h;
    if (!rst_n) begin
      mh[c]   = 3'b000;
      mrun[c] = 1'b0;
      mniv[c] = 0;
      mdiv[c] = 8'd0;
      mval[c] = 1'b0;
      mupd[c] = 1'b0;
    end else begin
      // level sampled two clocks earlier vs the one before it
      ev    = mh[c][1] ^ mh[c][2];
      mh[c] = {mh[c][1:0], s};
      od    = mdiv[c];
      ov    = mval[c];
      h     = mt - mlast[c];
      if (ev) begin
        if (!mrun[c]) begin
          mrun[c] = 1'b1;
          mniv[c] = 0;
        end else if (h == 1) begin
          mniv[c] = 0;
          mval[c] = 1'b0;
        end else begin
          miv[c][0] = miv[c][1];
          miv[c][1] = h - 1;
          if (mniv[c] < 2) mniv[c]++;
          if (mniv[c] == 2 && miv[c][0] == miv[c][1]) begin
            mval[c] = 1'b1;
            mdiv[c] = 8'(h - 1);
          end else begin
            mval[c] = 1'b0;
          end
        end
        mlast[c] = mt;
      end else if (mrun[c] && h == 257) begin
        mrun[c] = 1'b0;
        mdiv[c] = 8'd0;
        mval[c] = 1'b0;
      end
      mupd[c] = (od != mdiv[c]) || (ov != mval[c]);
    end
  endtask

  always @(posedge clk) begin
    mt++;
    mdl(0, sq_a);
    mdl(1, sq_b);
  end

  // stimulus state, owned by the main initial process
  int cyc = 0;
  int n_a = 0, n_b = 0, ph_a = 0, ph_b = 0, last_a = 0;
  int nua = 0, nub = 0;
  bit per_a = 0, per_b = 0, rnd_a = 0, rnd_b = 0, flip_a = 0, chk = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (chk) begin
        check($sformatf("ref_a@%0d", cyc), 32'({div_a, valid_a, upd_a}),
              32'({mdiv[0], mval[0], mupd[0]}));
        check($sformatf("ref_b@%0d", cyc), 32'({div_b, valid_b, upd_b}),
              32'({mdiv[1], mval[1], mupd[1]}));
      end
      if (upd_a) nua++;
      if (upd_b) nub++;
      if (flip_a) begin
        sq_a   = ~sq_a;
        flip_a = 0;
      end else if (rnd_a) begin
        if ($urandom_range(0, 5) == 0) sq_a = ~sq_a;
      end else if (per_a && n_a != 0) begin
        if (ph_a >= n_a) begin
          sq_a   = ~sq_a;
          ph_a   = 0;
          last_a = cyc;
        end else begin
          ph_a++;
        end
      end
      if (rnd_b) begin
        if ($urandom_range(0, 5) == 0) sq_b = ~sq_b;
      end else if (per_b && n_b != 0) begin
        if (ph_b >= n_b) begin
          sq_b = ~sq_b;
          ph_b = 0;
        end else begin
          ph_b++;
        end
      end
    end
  endtask

  task automatic restart(input int na, input int nb);
    per_a = 0; per_b = 0; rnd_a = 0; rnd_b = 0;
    sq_a  = 0; sq_b  = 0;
    rst_n = 0;
    step(2);
    rst_n = 1;
    n_a = na; n_b = nb; ph_a = 0; ph_b = 0;
    per_a = 1; per_b = 1;
    nua = 0; nub = 0;
  endtask

  typedef struct {
    int na; int nb; int cyc;
    int da; int va; int ua;
    int db; int vb; int ub;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int k, t0, m;
    tbl[0] = '{5,   0,   60,   5,   1, 1, 0,   0, 0};
    tbl[1] = '{0,   255, 1300, 0,   0, 0, 255, 1, 1};
    tbl[2] = '{1,   1,   40,   1,   1, 1, 1,   1, 1};
    tbl[3] = '{3,   7,   120,  3,   1, 1, 7,   1, 1};
    tbl[4] = '{255, 9,   1300, 255, 1, 1, 9,   1, 1};
    tbl[5] = '{12,  200, 1000, 12,  1, 1, 200, 1, 1};

    rst_n = 0;
    step(3);
    check("reset_a", 32'({div_a, valid_a, upd_a}), 0);
    check("reset_b", 32'({div_b, valid_b, upd_b}), 0);
    rst_n = 1;
    chk = 1;

    foreach (tbl[i]) begin
      restart(tbl[i].na, tbl[i].nb);
      step(tbl[i].cyc);
      check($sformatf("vec%0d_a", i), 32'({div_a, valid_a}),
            32'({tbl[i].da[7:0], tbl[i].va[0]}));
      check($sformatf("vec%0d_b", i), 32'({div_b, valid_b}),
            32'({tbl[i].db[7:0], tbl[i].vb[0]}));
      check($sformatf("vec%0d_upd_a", i), nua, tbl[i].ua);
      check($sformatf("vec%0d_upd_b", i), nub, tbl[i].ub);
    end

    // timeout after the signal stops
    restart(5, 0);
    step(60);
    check("to_lock", 32'({div_a, valid_a}), 32'({8'd5, 1'b1}));
    per_a = 0;
    t0 = last_a;
    k = 0;
    while (!upd_a && k < 400) begin
      step(1);
      k++;
    end
    check("to_seen", 32'(upd_a), 1);
    check("to_delay", cyc - t0, 260);
    check("to_out", 32'({div_a, valid_a}), 0);
    check("to_b", 32'({div_b, valid_b}), 0);
    step(1);
    check("to_upd_once", 32'(upd_a), 0);

    // period change 5 -> 9 while locked
    per_a = 1;
    step(60);
    check("sw_lock5", 32'({div_a, valid_a}), 32'({8'd5, 1'b1}));
    n_a = 9;
    k = 0;
    while (valid_a && k < 60) begin
      step(1);
      k++;
    end
    check("sw_drop", 32'({div_a, valid_a}), 32'({8'd5, 1'b0}));
    t0 = cyc;
    k = 0;
    while (!valid_a && k < 60) begin
      step(1);
      k++;
    end
    check("sw_relock", 32'({div_a, valid_a}), 32'({8'd9, 1'b1}));
    check("sw_gap", cyc - t0, 10);

    // coincident start, then a glitch on A only
    restart(3, 7);
    step(100);
    check("co_a", 32'({div_a, valid_a}), 32'({8'd3, 1'b1}));
    check("co_b", 32'({div_b, valid_b}), 32'({8'd7, 1'b1}));
    per_a  = 0;
    flip_a = 1;
    step(1);
    flip_a = 1;
    step(1);
    step(6);
    check("gl_a", 32'({div_a, valid_a}), 32'({8'd3, 1'b0}));
    check("gl_b", 32'({div_b, valid_b}), 32'({8'd7, 1'b1}));

    // one-cycle reset while both channels locked
    per_a = 1;
    step(60);
    check("rs_pre", 32'({valid_a, valid_b}), 3);
    rst_n = 0;
    step(1);
    rst_n = 1;
    check("rs_out", 32'({div_a, valid_a, upd_a, div_b, valid_b, upd_b}), 0);
    k = 0;
    while (!(valid_a && valid_b) && k < 100) begin
      step(1);
      k++;
    end
    check("rs_relock", 32'({div_a, valid_a, div_b, valid_b}),
          32'({8'd3, 1'b1, 8'd7, 1'b1}));

    // random traffic against the model
    for (int s = 0; s < 40; s++) begin
      m = $urandom_range(0, 9);
      per_a = (m < 5);
      rnd_a = (m >= 5 && m < 8);
      if (m < 5) n_a = (m == 0) ? $urandom_range(100, 255) : $urandom_range(1, 20);
      m = $urandom_range(0, 9);
      per_b = (m < 5);
      rnd_b = (m >= 5 && m < 8);
      if (m < 5) n_b = (m == 0) ? $urandom_range(100, 255) : $urandom_range(1, 20);
      if ($urandom_range(0, 15) == 0) begin
        rst_n = 0;
        step(1);
        rst_n = 1;
      end
      step(300);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
